lsu_master: RTL

LSU_MASTER -- requirements
Module: lsu_master

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_load_align.sv | 41 ++++
 rtl/lsu_master.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit bus master: op codes, error codes,
// FSM state encodings and the default bus-wait limit.
package lsu_pkg;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ADEL    = 2'b01;
    localparam logic [1:0] ERR_ADES    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam int TIMEOUT_DEFAULT = 255;

    // Stores occupy the top three op codes.
    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane select and sign/zero extension of the bus read word.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] bus_rdata,
    output logic [31:0] rdata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed lane, then extend according to the load flavour.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        rdata  = 32'h0000_0000;
        case (addr_lo)
            2'd0:    byte_s = bus_rdata[7:0];
            2'd1:    byte_s = bus_rdata[15:8];
            2'd2:    byte_s = bus_rdata[23:16];
            2'd3:    byte_s = bus_rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = bus_rdata[31:16];
        end else begin
            half_s = bus_rdata[15:0];
        end
        case (op_type)
            OP_LB:   rdata = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  rdata = {24'h00_0000, byte_s};
            OP_LH:   rdata = {{16{half_s[15]}}, half_s};
            OP_LHU:  rdata = {16'h0000, half_s};
            OP_LW:   rdata = bus_rdata;
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_master.sv
// Memory-stage bus master: checks alignment, issues one bus transaction per op,
// bounds the wait for bus_ack and returns extended load data.
module lsu_master
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        misaligned_s;
    logic [3:0]  be_s;
    logic [31:0] wrep_s;
    logic [31:0] load_ext_s;

    lsu_load_align u_load_align (
        .op_type   (op_q),
        .addr_lo   (lane_q),
        .bus_rdata (bus_rdata),
        .rdata     (load_ext_s)
    );

    // Alignment check, byte enables and store replication for the incoming op.
    always_comb begin
        misaligned_s = 1'b0;
        be_s         = 4'b0000;
        wrep_s       = 32'h0000_0000;
        case (op_type)
            OP_LB, OP_LBU, OP_SB: begin
                misaligned_s = 1'b0;
                be_s         = 4'b0001 << addr[1:0];
                wrep_s       = {4{wdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                misaligned_s = addr[0];
                if (addr[1]) begin
                    be_s = 4'b1100;
                end else begin
                    be_s = 4'b0011;
                end
                wrep_s = {2{wdata[15:0]}};
            end
            OP_LW, OP_SW: begin
                misaligned_s = (addr[1:0] != 2'b00);
                be_s         = 4'b1111;
                wrep_s       = wdata;
            end
            default: begin
                misaligned_s = 1'b0;
                be_s         = 4'b0000;
                wrep_s       = 32'h0000_0000;
            end
        endcase
    end

    // FSM next state, wait counter and next values of all registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        lane_d      = lane_q;
        err_code_d  = err_code_q;
        rdata_d     = rdata_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid && misaligned_s) begin
                    state_d = ST_FAULT;
                    if (is_store(op_type)) begin
                        err_code_d = ERR_ADES;
                    end else begin
                        err_code_d = ERR_ADEL;
                    end
                end else if (op_valid) begin
                    state_d     = ST_REQ;
                    cnt_d       = 8'd0;
                    op_d        = op_type;
                    lane_d      = addr[1:0];
                    bus_we_d    = is_store(op_type);
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = be_s;
                    bus_wdata_d = wrep_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // An ack on the limit cycle still completes normally.
                if (bus_ack) begin
                    state_d = ST_RESP;
                    if (!is_store(op_q)) begin
                        rdata_d = load_ext_s;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if ((cnt_q + 8'd1) == TIMEOUT_C) begin
                    state_d    = ST_FAULT;
                    err_code_d = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_RESP);
        err_d     = (state_d == ST_FAULT);
        bus_req_d = (state_d == ST_REQ);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            op_q        <= OP_LB;
            lane_q      <= 2'b00;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= ERR_NONE;
            rdata_q     <= 32'h0000_0000;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            rdata_q     <= rdata_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign rdata     = rdata_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule
